// File: rtl/compute_arbiter_if.sv
// Client request/operand/ack bundle plus the shared logic-op unit port, as seen by the arbiter.
interface compute_arbiter_if #(parameter int W = 4);
    logic         c0_req, c1_req;
    logic [W-1:0] c0_x, c1_x;
    logic [W-1:0] c0_y, c1_y;
    logic [1:0]   c0_op, c1_op;
    logic         c0_cont, c1_cont;
    logic         c0_ack, c1_ack;
    logic [W-1:0] c0_result, c1_result;
    logic [W-1:0] dev_x, dev_y;
    logic [1:0]   dev_opcode;
    logic         dev_rst, dev_req;
    logic [W-1:0] dev_result;
    logic         busy;
    logic [1:0]   owner;

    modport slave (
        input  c0_req, c1_req, c0_x, c1_x, c0_y, c1_y, c0_op, c1_op, c0_cont, c1_cont, dev_result,
        output c0_ack, c1_ack, c0_result, c1_result, dev_x, dev_y, dev_opcode, dev_rst, dev_req,
               busy, owner
    );

    modport master (
        output c0_req, c1_req, c0_x, c1_x, c0_y, c1_y, c0_op, c1_op, c0_cont, c1_cont, dev_result,
        input  c0_ack, c1_ack, c0_result, c1_result, dev_x, dev_y, dev_opcode, dev_rst, dev_req,
               busy, owner
    );
endinterface

// File: rtl/compute_arbiter.sv
// Round-robin arbiter sharing one W-bit logic-op accumulator unit between two clients; ack 4 edges after a fresh request, 3 after a chained one.
// Requests are level and held until ack; the losing client simply waits and is served on the next IDLE edge.
module compute_arbiter #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset,
    compute_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, COMMIT, RESP} state_t;

    state_t       state_q, state_d;
    logic         prio_q;
    logic         win_q;
    logic [W-1:0] lat_y_q;
    logic [1:0]   lat_op_q;

    logic         any_req, win, win_cont, fresh;
    logic [W-1:0] win_x, win_y;
    logic [1:0]   win_op;

    logic [W-1:0] dev_x_q, dev_x_d, dev_y_q, dev_y_d;
    logic [1:0]   dev_op_q, dev_op_d;
    logic         dev_rst_q, dev_rst_d, dev_req_q, dev_req_d;
    logic [1:0]   ack_q, ack_d;
    logic [W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [1:0]   owner_q, owner_d;
    logic         busy_q, busy_d;

    // prio_q names the client that wins a tie, i.e. the one not granted last.
    always_comb begin
        any_req  = bus.c0_req | bus.c1_req;
        win      = (bus.c0_req & bus.c1_req) ? prio_q : bus.c1_req;
        win_x    = win ? bus.c1_x    : bus.c0_x;
        win_y    = win ? bus.c1_y    : bus.c0_y;
        win_op   = win ? bus.c1_op   : bus.c0_op;
        win_cont = win ? bus.c1_cont : bus.c0_cont;
        fresh    = !win_cont || (owner_q != {1'b1, win});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = fresh ? LOAD : EXEC;
            LOAD:    state_d = EXEC;
            EXEC:    state_d = COMMIT;
            COMMIT:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one edge ahead and registered; x and cont are consumed on the grant edge itself,
    // so only y/op need to survive into LOAD.
    always_comb begin
        dev_x_d   = dev_x_q;
        dev_y_d   = dev_y_q;
        dev_op_d  = dev_op_q;
        dev_rst_d = 1'b0;
        dev_req_d = 1'b0;
        ack_d     = 2'b00;
        res0_d    = res0_q;
        res1_d    = res1_q;
        owner_d   = owner_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (fresh) begin
                        dev_x_d   = win_x;
                        dev_rst_d = 1'b1;
                    end else begin
                        dev_y_d   = win_y;
                        dev_op_d  = win_op;
                        dev_req_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                dev_y_d   = lat_y_q;
                dev_op_d  = lat_op_q;
                dev_req_d = 1'b1;
            end
            COMMIT: begin
                if (win_q) res1_d = bus.dev_result;
                else       res0_d = bus.dev_result;
                ack_d[win_q] = 1'b1;
                owner_d      = {1'b1, win_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q    <= 1'b0;
            win_q     <= 1'b0;
            lat_y_q   <= '0;
            lat_op_q  <= 2'b00;
            dev_x_q   <= '0;
            dev_y_q   <= '0;
            dev_op_q  <= 2'b00;
            dev_rst_q <= 1'b0;
            dev_req_q <= 1'b0;
            ack_q     <= 2'b00;
            res0_q    <= '0;
            res1_q    <= '0;
            owner_q   <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && any_req) begin
                win_q    <= win;
                prio_q   <= ~win;
                lat_y_q  <= win_y;
                lat_op_q <= win_op;
            end
            dev_x_q   <= dev_x_d;
            dev_y_q   <= dev_y_d;
            dev_op_q  <= dev_op_d;
            dev_rst_q <= dev_rst_d;
            dev_req_q <= dev_req_d;
            ack_q     <= ack_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.dev_x      = dev_x_q;
    assign bus.dev_y      = dev_y_q;
    assign bus.dev_opcode = dev_op_q;
    assign bus.dev_rst    = dev_rst_q;
    assign bus.dev_req    = dev_req_q;
    assign bus.c0_ack     = ack_q[0];
    assign bus.c1_ack     = ack_q[1];
    assign bus.c0_result  = res0_q;
    assign bus.c1_result  = res1_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_compute_arbiter.sv
// Directed and random checks of compute_arbiter against a transaction-level model of the shared accumulator unit.
module tb_compute_arbiter;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    compute_arbiter_if #(.W(4)) bus();
    compute_arbiter #(.W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return ~(a & b);
            2'd2:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    // Shared unit: rising dev_rst loads dev_x, falling dev_req commits f(acc, dev_y); result shows the accumulator.
    logic [3:0] acc = 4'h0;
    always @(posedge bus.dev_rst) begin #1; acc = bus.dev_x; end
    always @(negedge bus.dev_req) begin #1; acc = alu(acc, bus.dev_y, bus.dev_opcode); end
    assign bus.dev_result = acc;

    int rst_cyc = 0, req_cyc = 0, overlap = 0;
    always @(negedge clk) begin
        if (bus.dev_rst) rst_cyc++;
        if (bus.dev_req) req_cyc++;
        if (bus.dev_rst && bus.dev_req) overlap++;
    end

    // Model of which client's value the accumulator currently holds.
    bit         own_v = 0;
    int         own_c = 0;
    logic [3:0] acc_m = 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic r, input logic [3:0] x, input logic [3:0] y,
                         input logic [1:0] op, input logic cont);
        if (c == 0) begin
            bus.c0_req = r; bus.c0_x = x; bus.c0_y = y; bus.c0_op = op; bus.c0_cont = cont;
        end else begin
            bus.c1_req = r; bus.c1_x = x; bus.c1_y = y; bus.c1_op = op; bus.c1_cont = cont;
        end
    endtask

    function automatic logic get_ack(input int c);
        return (c == 0) ? bus.c0_ack : bus.c1_ack;
    endfunction

    function automatic logic [3:0] get_res(input int c);
        return (c == 0) ? bus.c0_result : bus.c1_result;
    endfunction

    function automatic logic [31:0] out_vec();
        return 32'({bus.dev_rst, bus.dev_req, bus.dev_x, bus.dev_y, bus.dev_opcode, bus.c0_ack,
                    bus.c1_ack, bus.c0_result, bus.c1_result, bus.busy, bus.owner});
    endfunction

    task automatic model_commit(input int c, input logic [3:0] r);
        own_v = 1; own_c = c; acc_m = r;
    endtask

    // One client alone: operands are scrambled after the grant edge, which must not matter.
    task automatic run_single(input string tag, input int c, input logic [3:0] x, input logic [3:0] y,
                              input logic [1:0] op, input logic cont);
        logic       fresh;
        logic [3:0] exp;
        int         r0, q0, n;
        fresh = !cont || !(own_v && own_c == c);
        exp   = alu(fresh ? x : acc_m, y, op);
        @(negedge clk);
        drive(c, 1'b1, x, y, op, cont);
        r0 = rst_cyc; q0 = req_cyc; n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                check({tag, ".busy"}, 32'(bus.busy), 32'd1);
                drive(c, 1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
            end
            if (get_ack(c)) begin n = i; break; end
        end
        check({tag, ".latency"}, n, fresh ? 4 : 3);
        check({tag, ".result"}, 32'(get_res(c)), 32'(exp));
        @(negedge clk);
        drive(c, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        check({tag, ".rst_pulses"}, rst_cyc - r0, fresh ? 1 : 0);
        check({tag, ".req_pulses"}, req_cyc - q0, 1);
        @(posedge clk); #1;
        check({tag, ".hold"}, 32'({get_ack(c), get_res(c)}), 32'({1'b0, exp}));
        model_commit(c, exp);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check(tag, out_vec(), 32'd0);
        reset = 1'b1;
        own_v = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, k, nacks, fresh_ops, r0, q0, seen;
        bit         pend[2];
        int         ops_since[2];
        logic [3:0] rx[2], ry[2], exp;
        logic [1:0] rop[2];
        logic       rcont[2], fresh;

        // Requests asserted while reset is low are ignored.
        reset = 1'b0;
        drive(0, 1'b1, 4'h5, 4'h6, 2'd3, 1'b0);
        drive(1, 1'b1, 4'h9, 4'h2, 2'd1, 1'b0);
        repeat (3) @(negedge clk);
        check("reset.outputs", out_vec(), 32'd0);
        reset = 1'b1;
        drive(0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        drive(1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        @(posedge clk); #1;
        check("reset.idle", 32'(bus.busy), 32'd0);

        run_single("fresh_and", 0, 4'hC, 4'hA, 2'd0, 1'b0);
        run_single("chain_xor", 0, 4'h0, 4'hF, 2'd3, 1'b1);
        check("chain.owner", 32'(bus.owner), 32'd2);

        // Simultaneous requests after reset: client 0 first, client 1 on the very next IDLE edge.
        do_reset("reset2.outputs");
        @(negedge clk);
        drive(0, 1'b1, 4'hF, 4'h0, 2'd2, 1'b0);
        drive(1, 1'b1, 4'h3, 4'h5, 2'd1, 1'b0);
        a0 = 0; a1 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.c0_ack && a0 == 0) begin
                a0 = i;
                check("tie.c0_result", 32'(bus.c0_result), 32'(alu(4'hF, 4'h0, 2'd2)));
                drive(0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
            end
            if (bus.c1_ack && a1 == 0) begin
                a1 = i;
                check("tie.c1_result", 32'(bus.c1_result), 32'(alu(4'h3, 4'h5, 2'd1)));
                drive(1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
                break;
            end
        end
        check("tie.c0_edge", a0, 4);
        check("tie.c1_edge", a1, 4 + 1 + 4);
        check("tie.owner", 32'(bus.owner), 32'd3);
        model_commit(1, alu(4'h3, 4'h5, 2'd1));
        @(posedge clk); #1;

        run_single("own_c0", 0, 4'h6, 4'h3, 2'd0, 1'b0);
        check("cross.owner", 32'(bus.owner), 32'd2);
        run_single("cross_cont", 1, 4'h9, 4'hC, 2'd3, 1'b1);

        // Abort mid-EXEC.
        @(negedge clk);
        drive(0, 1'b1, 4'h5, 4'hA, 2'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("abort.in_exec", 32'({bus.dev_req, bus.dev_rst}), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        @(posedge clk); #1;
        check("abort.outputs", out_vec(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        own_v = 0;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; seen |= int'(bus.c0_ack | bus.c1_ack); end
        check("abort.no_ack", seen, 0);
        run_single("after_abort", 0, 4'h7, 4'h9, 2'd0, 1'b1);

        // Random back-to-back traffic from both clients.
        pend = '{0, 0}; ops_since = '{0, 0};
        nacks = 0; fresh_ops = 0; r0 = rst_cyc; q0 = req_cyc;
        for (int cyc = 0; cyc < 1700; cyc++) begin
            @(negedge clk);
            k = -1;
            for (int c = 0; c < 2; c++) if (pend[c] && get_ack(c)) k = c;
            if (k >= 0) begin
                fresh = !rcont[k] || !(own_v && own_c == k);
                exp   = alu(fresh ? rx[k] : acc_m, ry[k], rop[k]);
                check("rnd.result", 32'(get_res(k)), 32'(exp));
                for (int c = 0; c < 2; c++) if (pend[c]) ops_since[c]++;
                check("rnd.fairness", 32'(ops_since[k] <= 2), 32'd1);
                model_commit(k, exp);
                fresh_ops += int'(fresh);
                nacks++;
                pend[k] = 0;
                drive(k, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
            end
            if (cyc >= 1500 && !pend[0] && !pend[1]) break;
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && c != k && cyc < 1500 && $urandom_range(2, 0) != 0) begin
                    rx[c] = 4'($urandom); ry[c] = 4'($urandom);
                    rop[c] = 2'($urandom); rcont[c] = 1'($urandom);
                    drive(c, 1'b1, rx[c], ry[c], rop[c], rcont[c]);
                    pend[c] = 1; ops_since[c] = 0;
                end
            end
        end
        check("rnd.drained", 32'({pend[0], pend[1]}), 32'd0);
        check("rnd.progress", 32'(nacks >= 150), 32'd1);
        check("rnd.rst_pulses", rst_cyc - r0, fresh_ops);
        check("rnd.req_pulses", req_cyc - q0, nacks);
        check("overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/compute_arbiter.md
COMPUTE_ARBITER -- requirements
Module: compute_arbiter

Interface
REQ-001 Parameter: W, default 4, operand/result width; SHALL match the shared 4-bit logic-op accumulator unit.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 c0_req, c1_req  input  1  client request, level, held until matching ack.
REQ-005 c0_x, c1_x  input  W  client initial accumulator operand.
REQ-006 c0_y, c1_y  input  W  client second operand.
REQ-007 c0_op, c1_op  input  2  opcode: 00 AND, 01 NAND, 10 NOR, 11 XOR.
REQ-008 c0_cont, c1_cont  input  1  1 = chain on the accumulator from the client's previous op.
REQ-009 c0_ack, c1_ack  output  1  one-cycle completion pulse.
REQ-010 c0_result, c1_result  output  W  result, valid while the matching ack is high, held afterwards.
REQ-011 dev_x, dev_y  output  W  operands driven to the shared unit.
REQ-012 dev_opcode  output  2  opcode driven to the shared unit.
REQ-013 dev_rst  output  1  load strobe to the unit; a rising edge loads dev_x into the accumulator.
REQ-014 dev_req  output  1  op strobe to the unit; a falling edge commits the result to the accumulator.
REQ-015 dev_result  input  W  current unit result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 owner  output  2  bit1 = valid, bit0 = client whose value the accumulator holds.

Function
REQ-018 All dev_* and client outputs SHALL be registered.
REQ-019 The FSM SHALL have states IDLE, LOAD, EXEC, COMMIT, RESP.
REQ-020 In IDLE with any request: grant is chosen, and the winner's x/y/op/cont are latched internally on that edge.
REQ-021 Arbitration: a single requester wins; if both request, the client not granted last wins; after reset, client 0 wins ties.
REQ-022 IDLE->LOAD, dev_x=x, dev_rst=1, when the winner's cont=0 or owner is not {valid, winner}; otherwise IDLE->EXEC.
REQ-023 LOAD->EXEC unconditionally: dev_rst=0, dev_y=y, dev_opcode=op, dev_req=1.
REQ-024 EXEC->COMMIT unconditionally: dev_req=0.
REQ-025 COMMIT->RESP: sample dev_result into the winner's result register; winner ack=1; owner={1, winner}.
REQ-026 RESP->IDLE: ack=0; the loser's pending request is served next with no extra idle cycle beyond IDLE itself.
REQ-027 Latency, request-sampling edge to ack high: 4 edges for a fresh op, 3 edges for a chained op.
REQ-028 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-029 Input changes during busy SHALL NOT affect the operation in progress.
REQ-030 dev_rst and dev_req SHALL never be high in the same cycle; each SHALL be high exactly one cycle per operation.
REQ-031 Result arithmetic SHALL be bitwise at width W with no carry or saturation.

Reset
REQ-032 When reset=0 at a rising edge: state=IDLE, dev_rst=0, dev_req=0, dev_x/dev_y/dev_opcode=0, acks=0, results=0, busy=0, owner=00, round-robin pointer favouring client 0.
REQ-033 Reset in any state, including mid-EXEC, SHALL abort without an ack; owner invalid forces the next op to LOAD.
REQ-034 Requests present while reset=0 SHALL be ignored; arbitration starts on the first edge with reset=1.

Verification
REQ-035 c0: x=C, y=A, op=00, cont=0 -> dev_rst pulse, then dev_req pulse; c0_ack 4 edges after the request; c0_result=8.
REQ-036 Then c0: cont=1, y=F, op=11 -> no dev_rst pulse; ack after 3 edges; c0_result=7.
REQ-037 Both clients request on the same edge after reset: c0 (x=F, y=0, op=10, result=0) completes first; c1 (x=3, y=5, op=01, result=E) follows; owner=11.
REQ-038 c1 sends cont=1 while owner=10 -> treated as fresh, dev_rst pulses with c1_x; result computed from c1_x.
REQ-039 reset=0 asserted during EXEC -> no ack, all outputs at reset values next cycle; next cont=1 request performs a LOAD.
REQ-040 Random back-to-back traffic -> dev_rst and dev_req never both high, and each client is served within 2 operations of requesting.
